uart_tx_engine: RTL and testbench

Serial transmitter half of the UART block. Pops bytes from the transmit FIFO with a single-cycle read strobe and serialises each byte on `TX` as an 8-N-1 frame: start bit, 8 data bits LSB first, optional parity, stop bit. Bit timing is derived from `UartClock` by a fixed oversample count. It sits between the FIFO_STATUS2 transmit FIFO and the external TX pin.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_engine_if.sv | 13 +
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_tx_engine.sv | 142 ++++++++++++++
 tb/tb_uart_tx_engine.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: state encoding, default bit timing, frame sizes.
// Used by both the transmitter and receiver halves of the UART block.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int DATA_BITS            = 8;

  // Frame lengths in bit periods: start + data + stop, optionally + parity.
  localparam int FRAME_BITS        = DATA_BITS + 2;
  localparam int FRAME_BITS_PARITY = DATA_BITS + 3;

endpackage

// File: rtl/uart_tx_engine_if.sv
// Transmit-FIFO read port: show-ahead head byte, occupancy and pop strobe.
// The FIFO side is the master; the transmit engine is the slave.
interface uart_tx_engine_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] TxData;
  logic [3:0]           TFcount;
  logic                 TFdataRead;

  modport master (output TxData, output TFcount, input TFdataRead);
  modport slave  (input TxData, input TFcount, output TFdataRead);

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit period with BitDone. Clear holds the count at zero.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic UartClock,
  input  logic Reset,
  input  logic Clear,
  output logic BitDone
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign BitDone = (count == LAST_COUNT) && !Clear;

  // Free-running bit counter that wraps at the end of every bit period.
  always_ff @(posedge UartClock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (Clear || (count == LAST_COUNT)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops bytes from the show-ahead TX FIFO and sends
// 8-N-1 frames (start, 8 data LSB first, stop) on a registered TX line.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic            UartClock,
  input  logic            Reset,
  uart_tx_engine_if.slave fifo,
  input  logic            TxEnable,
  output logic            TX,
  output logic            TxBusy
);

  logic [2:0]           state;
  logic [2:0]           bitIdx;
  logic [DATA_BITS-1:0] shiftReg;
  logic                 txLine;
  logic                 busy;
  logic                 bitDone;
  logic                 baudClear;
  logic                 loadReq;
  logic                 popNow;
`ifdef UART_TX_PARITY_EN
  logic                 parityBit;
`endif

  // Load condition; masked during reset so no pop can leak out while the
  // engine is being forced back to idle.
  assign loadReq = !Reset && TxEnable && (fifo.TFcount != 4'd0);

  // Pop from idle, or chain straight into the next frame on the last stop cycle.
  assign popNow = loadReq &&
                  ((state == ST_IDLE) || ((state == ST_STOP) && bitDone));

  assign fifo.TFdataRead = popNow;
  assign baudClear       = (state == ST_IDLE);
  assign TX              = txLine;
  assign TxBusy          = busy;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) baudTick (
    .UartClock (UartClock),
    .Reset     (Reset),
    .Clear     (baudClear),
    .BitDone   (bitDone)
  );

  // Frame sequencer; txLine is loaded with the level of the upcoming bit so
  // the pin changes exactly on the bit boundary with no combinational path.
  always_ff @(posedge UartClock or posedge Reset) begin
    if (Reset) begin
      state    <= ST_IDLE;
      bitIdx   <= 3'd0;
      shiftReg <= '0;
      txLine   <= 1'b1;
      busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parityBit <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (popNow) begin
            shiftReg <= fifo.TxData;
`ifdef UART_TX_PARITY_EN
            parityBit <= ^fifo.TxData;
`endif
            txLine   <= 1'b0;
            busy     <= 1'b1;
            bitIdx   <= 3'd0;
            state    <= ST_START;
          end
        end

        ST_START: begin
          if (bitDone) begin
            txLine <= shiftReg[0];
            bitIdx <= 3'd0;
            state  <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (bitDone) begin
            shiftReg <= {1'b0, shiftReg[DATA_BITS-1:1]};
            bitIdx   <= bitIdx + 3'd1;
            if (bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              txLine <= parityBit;
              state  <= ST_PARITY;
`else
              txLine <= 1'b1;
              state  <= ST_STOP;
`endif
            end else begin
              txLine <= shiftReg[1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bitDone) begin
            txLine <= 1'b1;
            state  <= ST_STOP;
          end
        end
`endif

        ST_STOP: begin
          if (bitDone) begin
            if (popNow) begin
              shiftReg <= fifo.TxData;
`ifdef UART_TX_PARITY_EN
              parityBit <= ^fifo.TxData;
`endif
              txLine   <= 1'b0;
              bitIdx   <= 3'd0;
              state    <= ST_START;
            end else begin
              txLine <= 1'b1;
              busy   <= 1'b0;
              state  <= ST_IDLE;
            end
          end
        end

        default: begin
          txLine <= 1'b1;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed testbench for uart_tx_engine with a small FIFO model.
// Honours UART_TX_PARITY_EN to expect the extra parity bit.
module tb_uart_tx_engine;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int HMAX = 1200;

  logic clk = 1'b0;
  logic rst;
  logic txEnable;
  logic tx;
  logic busy;

  uart_tx_engine_if fifo ();

  uart_tx_engine #(.CLKS_PER_BIT(CPB)) dut (
    .UartClock (clk),
    .Reset     (rst),
    .fifo      (fifo),
    .TxEnable  (txEnable),
    .TX        (tx),
    .TxBusy    (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] q[$];
  logic [7:0] popped;
  logic       hTx   [0:HMAX-1];
  logic       hBusy [0:HMAX-1];
  logic       hRd   [0:HMAX-1];

  int checks   = 0;
  int failures = 0;
  int nRd, nTxLow, busyRunStart, busyRunLen;
  int rdIdx [0:7];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic setFifo();
    fifo.TFcount = 4'(q.size());
    fifo.TxData  = (q.size() > 0) ? q[0] : 8'h00;
  endtask

  // One clock: sample at the falling edge, then apply any pop after the rising edge.
  task automatic tick(input int idx);
    @(negedge clk);
    hTx[idx]   = tx;
    hBusy[idx] = busy;
    hRd[idx]   = fifo.TFdataRead;
    @(posedge clk);
    #1;
    if (hRd[idx] && q.size() > 0) popped = q.pop_front();
    setFifo();
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) tick(i);
    nRd = 0; nTxLow = 0; busyRunStart = -1; busyRunLen = 0;
    for (int i = 0; i < 8; i++) rdIdx[i] = -1;
    for (int i = 0; i < n; i++) begin
      if (hRd[i]) begin
        if (nRd < 8) rdIdx[nRd] = i;
        nRd++;
      end
      if (!hTx[i]) nTxLow++;
      if (hBusy[i] && busyRunStart < 0) busyRunStart = i;
    end
    if (busyRunStart >= 0)
      for (int i = busyRunStart; i < n && hBusy[i]; i++) busyRunLen++;
  endtask

  // Check every cycle of every bit of a frame whose start bit begins at s.
  task automatic checkFrame(input int s, input logic [7:0] d, input string tag);
    int expBit, obs;
    for (int b = 0; b < FB; b++) begin
      if (b == 0)            expBit = 0;
      else if (b <= 8)       expBit = int'(d[b-1]);
      else if (b == FB - 1)  expBit = 1;
      else                   expBit = int'(^d);
      obs = expBit;
      for (int c = 0; c < CPB; c++)
        if (s + b*CPB + c < HMAX && int'(hTx[s + b*CPB + c]) != expBit)
          obs = int'(hTx[s + b*CPB + c]);
      chk($sformatf("%s_bit%0d", tag, b), obs, expBit);
    end
  endtask

  initial begin
    rst = 1'b1;
    txEnable = 1'b0;
    setFifo();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd", int'(fifo.TFdataRead), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single byte 0x55
    q.push_back(8'h55); txEnable = 1'b1; setFifo();
    capture(200);
    chk("s55_nrd", nRd, 1);
    chk("s55_rdidx", rdIdx[0], 0);
    chk("s55_busystart", busyRunStart, 1);
    chk("s55_busylen", busyRunLen, FB*CPB);
    checkFrame(1, 8'h55, "s55");
    chk("s55_idle_tx", int'(hTx[199]), 1);
    chk("s55_idle_busy", int'(hBusy[199]), 0);

    // Back-to-back 0xA5, 0x3C
    q.push_back(8'hA5); q.push_back(8'h3C); setFifo();
    capture(2*FB*CPB + 20);
    chk("b2b_nrd", nRd, 2);
    chk("b2b_gap", rdIdx[1] - rdIdx[0], FB*CPB);
    chk("b2b_busylen", busyRunLen, 2*FB*CPB);
    checkFrame(1, 8'hA5, "b2bA5");
    checkFrame(1 + FB*CPB, 8'h3C, "b2b3C");
    chk("b2b_idle_tx", int'(hTx[2*FB*CPB + 19]), 1);

    // Flow control: held off, then released, then dropped mid-second-frame
    txEnable = 1'b0;
    q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33); setFifo();
    capture(100);
    chk("fc_off_nrd", nRd, 0);
    chk("fc_off_txlow", nTxLow, 0);
    txEnable = 1'b1;
    capture(FB*CPB + 90);
    chk("fc_on_nrd", nRd, 2);
    chk("fc_on_gap", rdIdx[1] - rdIdx[0], FB*CPB);
    checkFrame(1, 8'h11, "fc11");
    txEnable = 1'b0;
    capture(150);
    chk("fc_drop_nrd", nRd, 0);
    chk("fc_drop_busylen", busyRunLen, FB*CPB - 89);
    chk("fc_drop_tx", int'(hTx[149]), 1);
    chk("fc_drop_left", q.size(), 1);
    q.delete(); setFifo();

`ifdef UART_TX_PARITY_EN
    // Parity frames
    txEnable = 1'b1;
    q.push_back(8'h55); setFifo();
    capture(200);
    chk("p55_busylen", busyRunLen, 176);
    chk("p55_pbit", int'(hTx[1 + 9*CPB + 8]), 0);
    checkFrame(1, 8'h55, "p55");
    q.push_back(8'h07); setFifo();
    capture(200);
    chk("p07_pbit", int'(hTx[1 + 9*CPB + 8]), 1);
    checkFrame(1, 8'h07, "p07");
`endif

    // Reset in the middle of data bit 3 of 0xF0
    txEnable = 1'b1;
    q.push_back(8'hF0); setFifo();
    capture(1 + CPB + 3*CPB + 8);
    chk("rmf_bit3", int'(hTx[CPB + 3*CPB + 8]), 0);
    chk("rmf_busy_pre", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("rmf_tx", int'(tx), 1);
    chk("rmf_busy", int'(busy), 0);
    q.push_back(8'h12); setFifo();
    #1;
    chk("rmf_rd_in_rst", int'(fifo.TFdataRead), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    capture(200);
    chk("rmf_nrd", nRd, 1);
    chk("rmf_rdidx", rdIdx[0], 0);
    chk("rmf_busylen", busyRunLen, FB*CPB);
    checkFrame(1, 8'h12, "rmf12");

    // Empty FIFO for 1000 cycles
    q.delete(); setFifo(); txEnable = 1'b1;
    capture(1000);
    chk("empty_nrd", nRd, 0);
    chk("empty_txlow", nTxLow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
